seq_pattern_gen: RTL and testbench
==================================

// Module: seq_pattern_gen
// PURPOSE
//   Serial pattern transmitter: the driving end of the single-bit serial line that the
//   sequence detectors sample. It latches a PAT_W-bit pattern and a repeat count, then
//   shifts the pattern out MSB-first, one bit per clk, for the requested number of
//   repetitions. It serves as the stimulus source for detector checks and as the serial
//   framer in link bring-up.
// PARAMETERS
//   PAT_W    6  pattern width in bits (>=2)
//   CNT_W    4  repeat-count width; max repetitions 2**CNT_W-1
//   GAP_LEN  2  idle cycles between repetitions (used only with SEQ_GEN_GAP_EN, >=1)
// PORTS
//   clk      in   1      rising-edge clock
//   reset    in   1      asynchronous, active-high reset
//   start    in   1      request; sampled only in IDLE
//   pattern  in   PAT_W  pattern to send, MSB first; latched when start is accepted
//   reps     in   CNT_W  number of repetitions; latched when start is accepted
//   abort    in   1      synchronous cancel while busy
//   x        out  1      serial data; 0 whenever valid=0
//   valid    out  1      x carries a pattern bit this cycle
//   last_bit out  1      final bit of final repetition (only asserted with valid)
//   busy     out  1      transfer in progress (start ignored)
//   done     out  1      one-cycle completion pulse
// BEHAVIOUR
//   - All outputs are registered. Reset (async, any time, including mid-transfer):
//     state=IDLE; x, valid, last_bit, busy and done all 0; latched regs cleared.
//   - States: IDLE, SHIFT, GAP (macro only), DONE.
//   - IDLE: start=1 at edge N latches pattern and reps.
//     - reps!=0: ->SHIFT. busy=1 from cycle N+1. First bit (pattern[PAT_W-1]) is on x
//       with valid=1 in cycle N+1 (latency 1).
//     - reps==0: ->DONE. done=1 in cycle N+1, busy stays 0, no valid bits.
//   - SHIFT: bit index counts PAT_W-1 down to 0, one bit per cycle, with valid=1.
//     - After bit 0, the remaining-rep counter decrements.
//     - Remaining>0: next cycle restarts at the MSB with no idle bit (back-to-back), so an
//       overlapping detector sees a continuous stream. With the macro, ->GAP instead.
//     - Remaining==0: last_bit=1 with bit 0; ->DONE.
//   - DONE: done=1, busy=0, valid=0 for exactly one cycle; ->IDLE. A start in this cycle
//     is ignored. A start in the following IDLE cycle is accepted.
//   - start while busy or in DONE: ignored. Changes on pattern/reps while busy have no
//     effect.
//   - abort=1 while busy (SHIFT or GAP): next cycle state=IDLE; x, valid, busy, last_bit=0;
//     no done pulse. abort in IDLE/DONE: no effect. If abort and start are both high in
//     IDLE, the start is accepted.
//   - Total valid cycles per transfer = PAT_W*reps. Without the macro, done asserts at
//     cycle N+1+PAT_W*reps.
// CONFIGURATION
//   SEQ_GEN_GAP_EN defined:
//     - Between repetitions (never after the last one), FSM enters GAP for GAP_LEN cycles.
//     - In GAP: valid=0, x=0, busy=1. Then ->SHIFT at the MSB.
//     - done asserts at N+1+PAT_W*reps+GAP_LEN*(reps-1).
//   SEQ_GEN_GAP_EN undefined:
//     - GAP state and its counter are not built; repetitions are strictly back-to-back.
// TESTING
//   1. Reset, then start with pattern=6'b101010, reps=1 -> x=1,0,1,0,1,0 with valid=1 in
//      cycles N+1..N+6; last_bit=1 in N+6; done=1 in N+7 only; busy=1 in N+1..N+6.
//   2. Pattern=6'b101010, reps=3 -> 18 consecutive valid bits alternating 1/0; done at
//      N+19. Looped into seq_detector, its y pulses at every 0 following a 10101 prefix.
//   3. reps=0 -> done=1 in N+1, valid never asserts, busy stays 0.
//   4. Start with pattern=6'b110011, reps=2; at cycle N+3 pulse start with pattern=6'b000000
//      -> stream is still 110011110011 and exactly one done pulse.
//   5. Abort on the 3rd bit -> valid=0 and busy=0 from the next cycle, no done pulse.
//      Separately, assert reset mid-transfer -> all outputs 0 before the next clk edge.
//   6. SEQ_GEN_GAP_EN, GAP_LEN=2, pattern=6'b101010, reps=2 -> 6 valid bits, 2 cycles with
//      valid=0/x=0, 6 valid bits, done at N+15.

Source files
------------

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts a latched PAT_W-bit pattern out MSB-first for a latched
// number of repetitions. Define SEQ_GEN_GAP_EN to insert GAP_LEN idle cycles between repetitions.
module seq_pattern_gen #(
  parameter int PAT_W   = 6,
  parameter int CNT_W   = 4,
  parameter int GAP_LEN = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] reps,
  input  logic             abort,
  output logic             x,
  output logic             valid,
  output logic             last_bit,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0] ONE_REP = CNT_W'(1);

  if (PAT_W < 2) begin : g_bad_pat_w
    $error("seq_pattern_gen: PAT_W must be >= 2");
  end
  if (GAP_LEN < 1) begin : g_bad_gap_len
    $error("seq_pattern_gen: GAP_LEN must be >= 1");
  end

`ifdef SEQ_GEN_GAP_EN
  localparam int GAP_W = $clog2(GAP_LEN + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;
  logic [GAP_W-1:0] gap_q, gap_d;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             x_q, x_d, valid_q, valid_d, last_q, last_d;
  logic             busy_q, busy_d, done_q, done_d;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
`ifdef SEQ_GEN_GAP_EN
    gap_d   = gap_q;
`endif
    x_d     = 1'b0;
    valid_d = 1'b0;
    last_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          pat_d = pattern;
          rem_d = reps;
          if (reps != '0) begin
            state_d = SHIFT;
            idx_d   = IDX_MSB;
            x_d     = pattern[PAT_W-1];
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (idx_q == '0) begin
          rem_d = rem_q - ONE_REP;
          if (rem_q == ONE_REP) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
`ifdef SEQ_GEN_GAP_EN
            state_d = GAP;
            gap_d   = GAP_W'(GAP_LEN - 1);
            busy_d  = 1'b1;
`else
            idx_d   = IDX_MSB;
            x_d     = pat_q[PAT_W-1];
            valid_d = 1'b1;
            busy_d  = 1'b1;
`endif
          end
        end else begin
          // Flag the upcoming bit 0 of the final repetition so last_bit lines up with it.
          idx_d   = idx_q - 1'b1;
          x_d     = pat_q[idx_q - 1'b1];
          valid_d = 1'b1;
          busy_d  = 1'b1;
          last_d  = (rem_q == ONE_REP) && (idx_q == IDX_W'(1));
        end
      end
`ifdef SEQ_GEN_GAP_EN
      GAP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (gap_q == '0) begin
          state_d = SHIFT;
          idx_d   = IDX_MSB;
          x_d     = pat_q[PAT_W-1];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          gap_d  = gap_q - 1'b1;
          busy_d = 1'b1;
        end
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pat_q   <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
`ifdef SEQ_GEN_GAP_EN
      gap_q   <= '0;
`endif
      x_q     <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
`ifdef SEQ_GEN_GAP_EN
      gap_q   <= gap_d;
`endif
      x_q     <= x_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign x        = x_q;
  assign valid    = valid_q;
  assign last_bit = last_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen; honours SEQ_GEN_GAP_EN when defined.
module tb_seq_pattern_gen;
  localparam int PAT_W   = 6;
  localparam int CNT_W   = 4;
  localparam int GAP_LEN = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic [CNT_W-1:0] reps = '0;
  logic             abort = 1'b0;
  logic             x, valid, last_bit, busy, done;

  int vectors = 0;
  int miscompares = 0;

  seq_pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_LEN(GAP_LEN)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .reps(reps),
    .abort(abort), .x(x), .valid(valid), .last_bit(last_bit), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic ex, input logic ev, input logic el,
                      input logic eb, input logic ed);
    chk({tag, ".x"}, x, ex);
    chk({tag, ".valid"}, valid, ev);
    chk({tag, ".last_bit"}, last_bit, el);
    chk({tag, ".busy"}, busy, eb);
    chk({tag, ".done"}, done, ed);
  endtask

  // Checks a transfer whose first bit is on the line now; optionally pulses a
  // conflicting start (pattern all-zero) during stream bit number inj.
  task automatic stream(input string tag, input logic [PAT_W-1:0] pat, input int nreps,
                        input int inj);
    int k = 0;
    for (int r = 0; r < nreps; r++) begin
      for (int b = PAT_W - 1; b >= 0; b--) begin
        outs($sformatf("%s.bit%0d", tag, k), pat[b], 1'b1,
             (r == nreps - 1) && (b == 0), 1'b1, 1'b0);
        if (k == inj) begin
          start = 1'b1;
          pattern = '0;
        end
        cyc();
        start = 1'b0;
        k++;
      end
`ifdef SEQ_GEN_GAP_EN
      if (r < nreps - 1) begin
        for (int g = 0; g < GAP_LEN; g++) begin
          outs($sformatf("%s.gap%0d_%0d", tag, r, g), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
          cyc();
        end
      end
`endif
    end
    outs({tag, ".done"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc();
    outs({tag, ".after"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic launch(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] n);
    start = 1'b1;
    pattern = pat;
    reps = n;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    outs("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Single repetition of 101010
    launch(6'b101010, 4'd1);
    stream("t1", 6'b101010, 1, -1);

    // Three repetitions, back-to-back (or gapped with the macro)
    launch(6'b101010, 4'd3);
    stream("t2", 6'b101010, 3, -1);

    // reps=0 gives a lone done; a start held through DONE is taken one cycle later
    launch(6'b111111, 4'd0);
    outs("t3.done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    pattern = 6'b110011;
    reps = 4'd1;
    cyc();
    outs("t3.ignored", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    start = 1'b0;
    stream("t3b", 6'b110011, 1, -1);

    // Start during a transfer is ignored
    launch(6'b110011, 4'd2);
    stream("t4", 6'b110011, 2, 2);
    cyc();
    outs("t4.quiet", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Abort on the third bit
    launch(6'b101010, 4'd2);
    outs("t5.b0", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc();
    outs("t5.b1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc();
    outs("t5.b2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    outs("t5.aborted", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    outs("t5.nodone", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Abort together with start in IDLE: the start wins
    start = 1'b1;
    abort = 1'b1;
    pattern = 6'b100001;
    reps = 4'd1;
    cyc();
    start = 1'b0;
    abort = 1'b0;
    stream("t5c", 6'b100001, 1, -1);

    // Asynchronous reset mid-transfer clears outputs before the next edge
    launch(6'b111111, 4'd3);
    cyc();
    outs("t5r.pre", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    #1 reset = 1'b1;
    #1;
    outs("t5r.reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    reset = 1'b0;
    cyc();
    outs("t5r.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Fresh transfer after the reset
    launch(6'b011110, 4'd1);
    stream("t5r.resume", 6'b011110, 1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
